ic_tag_ctrl: RTL and testbench

IC_TAG_CTRL -- requirements
Module: ic_tag_ctrl

---
 rtl/ic_pkg.sv | 33 +++
 rtl/ic_tag_top.sv | 52 +++++
 rtl/ic_tag_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ic_tag_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ic_pkg.sv
// -----------------------------------------------------------------------------
// ic_pkg
// Shared definitions for the instruction-cache tag controller:
//   - default geometry (tag width, index width, fetch address width)
//   - lookup FSM state encoding
//   - saturating 32-bit counter increment helper
// -----------------------------------------------------------------------------
package ic_pkg;

   localparam int unsigned IC_TAG_DW = 20;   // tag bits
   localparam int unsigned IC_TAG_AW = 9;    // index bits (512 lines)
   localparam int unsigned IC_ADDR_W = 32;   // fetch address bits

   // Explicit codes keep the encoding stable for anything that decodes it
   // from a waveform or a debug bus.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD    = 3'd1,
      ST_CMP   = 3'd2,
      ST_MREQ  = 3'd3,
      ST_MWAIT = 3'd4,
      ST_FILL  = 3'd5,
      ST_RESP  = 3'd6
   } ic_state_e;

   localparam logic [31:0] IC_CNT_MAX = 32'hFFFF_FFFF;

   // Counters stick at all-ones instead of wrapping back to zero.
   function automatic logic [31:0] ic_sat_inc(input logic [31:0] v);
      return (v == IC_CNT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/ic_tag_top.sv
// -----------------------------------------------------------------------------
// ic_tag_top
// Simple dual-port tag RAM: port A writes, port B reads with one cycle of
// registered read latency. Contents are not reset; the controller's valid
// bits decide whether an entry may be used.
//
// Ports
//   clka_i   write clock
//   wea_i    write enable
//   addra_i  write index
//   dina_i   write tag
//   clkb_i   read clock
//   enb_i    read enable; doutb_o holds its last value while low
//   addrb_i  read index
//   doutb_o  read tag, valid the cycle after enb_i
// -----------------------------------------------------------------------------
module ic_tag_top #(
   parameter int unsigned DW = 20,
   parameter int unsigned AW = 9
) (
   input  logic          clka_i,
   input  logic          wea_i,
   input  logic [AW-1:0] addra_i,
   input  logic [DW-1:0] dina_i,
   input  logic          clkb_i,
   input  logic          enb_i,
   input  logic [AW-1:0] addrb_i,
   output logic [DW-1:0] doutb_o
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_data_q;

   always_ff @(posedge clka_i) begin
      if (wea_i) begin
         mem_q[addra_i] <= dina_i;
      end
   end

   // Holding the read register while disabled lets the controller compare
   // against it a cycle later without re-reading the array.
   always_ff @(posedge clkb_i) begin
      if (enb_i) begin
         rd_data_q <= mem_q[addrb_i];
      end
   end

   assign doutb_o = rd_data_q;

endmodule

// File: rtl/ic_tag_ctrl.sv
// -----------------------------------------------------------------------------
// ic_tag_ctrl
// Tag lookup and refill controller for a direct-mapped instruction cache.
// One request is in flight at a time:
//   IDLE -> RD -> CMP -> RESP                         (hit)
//   IDLE -> RD -> CMP -> MREQ -> MWAIT -> FILL -> RESP (miss)
// Valid bits live here as flops; tags live in ic_tag_top.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/ready     lookup request handshake, req_addr = fetch address
//   resp_valid/ready    response handshake; resp_hit=1 hit, 0 filled after miss;
//                       resp_addr echoes the request address
//   refill_valid/ready  line refill request, refill_addr line aligned
//   refill_done         single-cycle pulse: refill data has landed
//   flush               invalidate-all pulse
//   hit_cnt, miss_cnt   saturating response counters
// -----------------------------------------------------------------------------
module ic_tag_ctrl
   import ic_pkg::*;
#(
   parameter int unsigned TAG_DW = IC_TAG_DW,
   parameter int unsigned TAG_AW = IC_TAG_AW,
   parameter int unsigned ADDR_W = IC_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_hit,
   output logic [ADDR_W-1:0] resp_addr,
   output logic              refill_valid,
   input  logic              refill_ready,
   output logic [ADDR_W-1:0] refill_addr,
   input  logic              refill_done,
   input  logic              flush,
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt
);

   localparam int unsigned OFF_W = ADDR_W - TAG_DW - TAG_AW;
   localparam int unsigned LINES = 2 ** TAG_AW;

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   ic_state_e          state_q, state_d;
   logic [LINES-1:0]   valid_q;
   logic               flush_pend_q;
   logic [31:0]        hit_cnt_q, miss_cnt_q;

   // Request data, captured on acceptance (no reset needed)
   logic [ADDR_W-1:0]  addr_q;
   logic               resp_hit_q;

   // ---------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------
   logic [TAG_AW-1:0]  req_idx;
   logic [TAG_DW-1:0]  lat_tag;
   logic [TAG_AW-1:0]  lat_idx;

   assign req_idx = req_addr[OFF_W +: TAG_AW];
   assign lat_tag = addr_q[ADDR_W-1 -: TAG_DW];
   assign lat_idx = addr_q[OFF_W +: TAG_AW];

   // ---------------------------------------------------------------------
   // Handshake qualifiers
   // ---------------------------------------------------------------------
   logic in_idle;
   logic flush_now;
   logic accept;
   logic resp_hs;

   assign in_idle   = (state_q == ST_IDLE);
   // A flush (live or parked) is applied on the first IDLE cycle and
   // blocks acceptance in that same cycle.
   assign flush_now = in_idle && (flush || flush_pend_q);
   // rst_n is folded in so req_ready reads 0 for the whole reset window.
   assign req_ready = rst_n && in_idle && !flush && !flush_pend_q;
   assign accept    = req_valid && req_ready;
   assign resp_hs   = (state_q == ST_RESP) && resp_ready;

   // ---------------------------------------------------------------------
   // Tag RAM
   // ---------------------------------------------------------------------
   logic              ram_we;
   logic [TAG_DW-1:0] ram_rdata;

   // Read is issued only on acceptance and writes only happen in FILL,
   // so the two ports never touch the same index in the same cycle.
   assign ram_we = (state_q == ST_FILL);

   ic_tag_top #(
      .DW (TAG_DW),
      .AW (TAG_AW)
   ) u_tag_ram (
      .clka_i  (clk),
      .wea_i   (ram_we),
      .addra_i (lat_idx),
      .dina_i  (lat_tag),
      .clkb_i  (clk),
      .enb_i   (accept),
      .addrb_i (req_idx),
      .doutb_o (ram_rdata)
   );

   // RAM output is stable from RD onwards, so the compare in CMP sees
   // the entry for this request.
   logic lookup_hit;
   assign lookup_hit = valid_q[lat_idx] && (ram_rdata == lat_tag);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:  if (accept)       state_d = ST_RD;
         ST_RD:                      state_d = ST_CMP;
         ST_CMP:   state_d = lookup_hit ? ST_RESP : ST_MREQ;
         ST_MREQ:  if (refill_ready) state_d = ST_MWAIT;
         ST_MWAIT: if (refill_done)  state_d = ST_FILL;
         ST_FILL:                    state_d = ST_RESP;
         ST_RESP:  if (resp_ready)   state_d = ST_IDLE;
         default:                    state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Control registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         valid_q      <= '0;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q <= state_d;

         if (flush_now) begin
            valid_q <= '0;
         end else if (state_q == ST_FILL) begin
            valid_q[lat_idx] <= 1'b1;
         end

         // Parked flushes are consumed by the IDLE cycle that applies them.
         if (in_idle) begin
            flush_pend_q <= 1'b0;
         end else if (flush) begin
            flush_pend_q <= 1'b1;
         end

         if (resp_hs) begin
            if (resp_hit_q) begin
               hit_cnt_q <= ic_sat_inc(hit_cnt_q);
            end else begin
               miss_cnt_q <= ic_sat_inc(miss_cnt_q);
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Request data registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q <= req_addr;
      end
      // A miss keeps resp_hit at 0 through the refill path.
      if (state_q == ST_CMP) begin
         resp_hit_q <= lookup_hit;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign resp_valid   = (state_q == ST_RESP);
   assign resp_hit     = resp_hit_q;
   assign resp_addr    = addr_q;
   assign refill_valid = (state_q == ST_MREQ);
   assign refill_addr  = {lat_tag, lat_idx, {OFF_W{1'b0}}};
   assign hit_cnt      = hit_cnt_q;
   assign miss_cnt     = miss_cnt_q;

endmodule

// File: tb/tb_ic_tag_ctrl.sv
module tb_ic_tag_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic        resp_hit;
   logic [31:0] resp_addr;
   logic        refill_valid;
   logic        refill_ready = 1'b0;
   logic [31:0] refill_addr;
   logic        refill_done = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   always #5 clk = ~clk;

   ic_tag_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_hit     (resp_hit),
      .resp_addr    (resp_addr),
      .refill_valid (refill_valid),
      .refill_ready (refill_ready),
      .refill_addr  (refill_addr),
      .refill_done  (refill_done),
      .flush        (flush),
      .hit_cnt      (hit_cnt),
      .miss_cnt     (miss_cnt)
   );

   int          n_vec = 0;
   int          n_err = 0;
   int unsigned cyc = 0;
   int          resp_seen = 0;
   bit          saw_refill = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] addr;
      bit          hit;
      int unsigned acc;
   } exp_t;
   exp_t sb[$];

   // Reference model: a direct-mapped directory of 512 lines.
   bit          m_valid [512];
   int unsigned m_tag   [512];
   int unsigned m_hits = 0;
   int unsigned m_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bail(input string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   endtask

   function automatic void model_clear();
      for (int i = 0; i < 512; i++) m_valid[i] = 0;
   endfunction

   // Returns predicted hit and records the line as present afterwards.
   function automatic bit model_lookup(input logic [31:0] a);
      int unsigned idx;
      int unsigned tag;
      bit          h;
      idx = (a / 8) % 512;
      tag = a / 4096;
      h = m_valid[idx] && (m_tag[idx] == tag);
      m_valid[idx] = 1;
      m_tag[idx]   = tag;
      return h;
   endfunction

   // ---------------------------------------------------------------------
   // Monitor / scoreboard
   // ---------------------------------------------------------------------
   bit          prev_rv = 0;
   bit          held_v = 0;
   logic [31:0] held_addr;
   logic        held_hit;
   bit          cnt_chk = 0;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         prev_rv = 0;
         held_v  = 0;
      end else begin
         if (refill_valid) saw_refill = 1;
         if (resp_valid) begin
            check("req_ready_during_resp", 32'(req_ready), 32'd0);
            if (held_v) begin
               check("resp_addr_stable", resp_addr, held_addr);
               check("resp_hit_stable", 32'(resp_hit), 32'(held_hit));
            end
            if (!prev_rv) begin
               if (sb.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL unexpected_resp: got addr %h with nothing outstanding", resp_addr);
               end else begin
                  e = sb[0];
                  check("resp_addr", resp_addr, e.addr);
                  check("resp_hit", 32'(resp_hit), 32'(e.hit));
                  check("refill_issued", 32'(saw_refill), 32'(!e.hit));
                  if (e.hit) check("hit_latency", cyc - e.acc, 32'd2);
               end
            end
            if (resp_ready) begin
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  if (e.hit) m_hits++;
                  else       m_miss++;
               end
               held_v  = 0;
               cnt_chk = 1;
               resp_seen++;
            end else begin
               held_v    = 1;
               held_addr = resp_addr;
               held_hit  = resp_hit;
            end
         end else begin
            held_v = 0;
         end
         prev_rv = resp_valid;
      end
   end

   always @(posedge clk) begin
      #1;
      if (cnt_chk) begin
         cnt_chk = 0;
         check("hit_cnt", hit_cnt, m_hits);
         check("miss_cnt", miss_cnt, m_miss);
      end
   end

   // ---------------------------------------------------------------------
   // Driver: one complete lookup transaction
   // ---------------------------------------------------------------------
   task automatic do_req(input logic [31:0] a, input bit flush_wait,
                         input bit flush_with, input bit bp);
      int   g = 0;
      int   start;
      int   dly;
      int   bpc = 0;
      bit   hs_done = 0;
      bit   rv_prev = 0;
      bit   rr_prev = 0;
      bit   flushed = 0;
      exp_t e;

      @(posedge clk); #1;
      req_addr  = a;
      req_valid = 1'b1;
      if (flush_with) begin
         flush = 1'b1;
         @(negedge clk);
         check("req_ready_under_flush", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
         flush = 1'b0;
         model_clear();
      end
      do begin
         @(negedge clk);
         g++;
         if (g > 50) bail("accept");
      end while (!req_ready);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      saw_refill = 0;
      e.addr = a;
      e.acc  = cyc;
      e.hit  = model_lookup(a);
      sb.push_back(e);

      start = resp_seen;
      dly   = int'($urandom_range(1, 4));
      g     = 0;
      while (resp_seen == start) begin
         @(posedge clk); #1;
         g++;
         if (g > 400) bail("response");
         flush       = 1'b0;
         refill_done = 1'b0;
         if (!hs_done && rv_prev && rr_prev) begin
            hs_done = 1;
            if (flush_wait) begin
               flush   = 1'b1;
               flushed = 1;
            end
         end else if (hs_done && dly > 0) begin
            dly--;
            if (dly == 0) refill_done = 1'b1;
         end
         // Stray completions outside the wait state must be ignored.
         if (!hs_done && !refill_valid && $urandom_range(0, 7) == 0) refill_done = 1'b1;
         if (refill_valid) begin
            check("refill_addr", refill_addr, {a[31:3], 3'b000});
            refill_ready = ($urandom_range(0, 2) == 0);
         end else begin
            refill_ready = 1'b0;
         end
         rv_prev = refill_valid;
         rr_prev = refill_ready;
         if (resp_valid) begin
            bpc++;
            resp_ready = bp ? (bpc > 5) : ($urandom_range(0, 2) != 0);
         end else begin
            resp_ready = bp ? 1'b0 : ($urandom_range(0, 1) == 1);
         end
      end
      flush        = 1'b0;
      refill_done  = 1'b0;
      refill_ready = 1'b0;
      resp_ready   = 1'b0;
      if (flushed) model_clear();
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int g;
      logic [31:0] a;
      model_clear();

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_refill_valid", 32'(refill_valid), 32'd0);
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_miss_cnt", miss_cnt, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);

      // Cold miss, then hit, then conflict on index 1
      do_req(32'h0000_1008, 0, 0, 0);
      do_req(32'h0000_1008, 0, 0, 0);
      do_req(32'h0000_2008, 0, 0, 0);
      do_req(32'h0000_1008, 0, 0, 0);
      // Flush during refill wait, then the same line misses
      do_req(32'h0000_4008, 1, 0, 0);
      do_req(32'h0000_4008, 0, 0, 0);
      // Response backpressure on a hit
      do_req(32'h0000_4008, 0, 0, 1);
      // Flush colliding with a request
      do_req(32'h0000_4008, 0, 1, 0);

      for (int i = 0; i < 250; i++) begin
         a = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 7)) << 3)
             | 32'($urandom_range(0, 7));
         do_req(a, ($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 9) == 0));
      end
      check("sb_drained", 32'(sb.size()), 32'd0);

      // Reset while the refill request is outstanding
      @(posedge clk); #1;
      refill_ready = 1'b0;
      req_addr     = 32'h0000_3008;
      req_valid    = 1'b1;
      g = 0;
      do begin
         @(negedge clk);
         g++;
         if (g > 50) bail("rst_accept");
      end while (!req_ready);
      @(posedge clk); #1;
      req_valid = 1'b0;
      g = 0;
      do begin
         @(negedge clk);
         g++;
         if (g > 20) bail("rst_mreq");
      end while (!refill_valid);
      #1;
      rst_n = 1'b0;
      #1;
      check("mreq_rst_refill_valid", 32'(refill_valid), 32'd0);
      check("mreq_rst_req_ready", 32'(req_ready), 32'd0);
      check("mreq_rst_resp_valid", 32'(resp_valid), 32'd0);
      check("mreq_rst_hit_cnt", hit_cnt, 32'd0);
      check("mreq_rst_miss_cnt", miss_cnt, 32'd0);
      model_clear();
      m_hits = 0;
      m_miss = 0;
      @(posedge clk); #1;
      rst_n       = 1'b1;
      refill_done = 1'b1;
      @(posedge clk); #1;
      refill_done = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("stray_done_refill_valid", 32'(refill_valid), 32'd0);
      check("stray_done_resp_valid", 32'(resp_valid), 32'd0);
      check("stray_done_req_ready", 32'(req_ready), 32'd1);
      do_req(32'h0000_1008, 0, 0, 0);
      do_req(32'h0000_3008, 0, 0, 0);
      check("sb_drained_end", 32'(sb.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
